// File: rtl/sd_sector_loader.sv
// Boot-time bus master: copies consecutive 512-byte SD sectors into RAM through the
// SD register interface while holding the CPU off the bus.
module sd_sector_loader #(
  parameter int            TW             = 24,
  parameter logic [TW-1:0] TIMEOUT_CYCLES = 24'd4000000
) (
  input  logic        clk_i,
  input  logic        rst_n_i,
  input  logic        start_i,
  input  logic [31:0] sector_base_i,
  input  logic [7:0]  sector_count_i,
  input  logic [15:0] mem_base_i,
  output logic        sd_cs_o,
  output logic        sd_rw_n_o,
  output logic [7:0]  sd_addr_o,
  output logic [7:0]  sd_wdata_o,
  input  logic [7:0]  sd_rdata_i,
  output logic [15:0] mem_addr_o,
  output logic [7:0]  mem_data_o,
  output logic        mem_we_o,
  output logic        busy_o,
  output logic        cpu_hold_o,
  output logic        done_o,
  output logic        error_o
);

  typedef enum logic [3:0] {
    S_IDLE,
    S_CLR_DONE,
    S_SET_ADDR,
    S_WAIT_IDLE,
    S_START_RD,
    S_POLL_DONE,
    S_SET_PAGE,
    S_READ_BUF,
    S_NEXT,
    S_FINISH,
    S_ERROR
  } state_t;

  localparam logic [7:0]    REG_STATUS = 8'h04;
  localparam logic [7:0]    REG_CMD    = 8'h05;
  localparam logic [7:0]    REG_PAGE   = 8'h07;
  localparam logic [7:0]    REG_DONE   = 8'h0a;
  localparam logic [TW-1:0] TMO_LAST   = TIMEOUT_CYCLES - TW'(1);

  // The state names the access currently on the bus; each edge consumes that
  // access's result and registers the next access onto the bus outputs.
  state_t        state;
  logic [31:0]   sec;
  logic [7:0]    cnt;
  logic [15:0]   mem_ptr;
  logic [1:0]    page;
  logic [6:0]    idx;
  logic [TW-1:0] tmo;
  logic          done_pend;

  logic [1:0] nxt_byte;
  assign nxt_byte   = idx[1:0] + 2'd1;
  assign cpu_hold_o = busy_o;

  always_ff @(posedge clk_i or negedge rst_n_i) begin
    // NOTE: every register here, including datapath, is async-reset so an abort
    // mid-load leaves no stale bus or RAM strobe behind.
    if (!rst_n_i) begin
      state      <= S_IDLE;
      sec        <= '0;
      cnt        <= '0;
      mem_ptr    <= '0;
      page       <= '0;
      idx        <= '0;
      tmo        <= '0;
      done_pend  <= 1'b0;
      sd_cs_o    <= 1'b0;
      sd_rw_n_o  <= 1'b1;
      sd_addr_o  <= '0;
      sd_wdata_o <= '0;
      mem_addr_o <= '0;
      mem_data_o <= '0;
      mem_we_o   <= 1'b0;
      busy_o     <= 1'b0;
      done_o     <= 1'b0;
      error_o    <= 1'b0;
    end else begin
      // NOTE: defaults first, all non-blocking: the bus returns to idle and
      // mem_we_o drops unless the branch below schedules another access.
      sd_cs_o    <= 1'b0;
      sd_rw_n_o  <= 1'b1;
      sd_addr_o  <= '0;
      sd_wdata_o <= '0;
      mem_we_o   <= 1'b0;

      case (state)
        S_IDLE: begin
          if (done_pend) begin
            done_o    <= 1'b1;
            done_pend <= 1'b0;
          end
          if (start_i) begin
            sec     <= sector_base_i;
            cnt     <= sector_count_i;
            mem_ptr <= mem_base_i;
            done_o  <= 1'b0;
            error_o <= 1'b0;
            if (sector_count_i == 8'd0) begin
              done_pend <= 1'b1;
            end else begin
              busy_o    <= 1'b1;
              state     <= S_CLR_DONE;
              sd_cs_o   <= 1'b1;
              sd_addr_o <= REG_DONE;
            end
          end
        end

        S_CLR_DONE: begin
          state      <= S_SET_ADDR;
          idx        <= '0;
          sd_cs_o    <= 1'b1;
          sd_rw_n_o  <= 1'b0;
          sd_addr_o  <= 8'h00;
          sd_wdata_o <= sec[7:0];
        end

        S_SET_ADDR: begin
          sd_cs_o <= 1'b1;
          if (idx[1:0] != 2'd3) begin
            idx        <= idx + 7'd1;
            sd_rw_n_o  <= 1'b0;
            sd_addr_o  <= {6'b0, nxt_byte};
            sd_wdata_o <= sec[{nxt_byte, 3'b000} +: 8];
          end else begin
            state     <= S_WAIT_IDLE;
            tmo       <= '0;
            sd_addr_o <= REG_STATUS;
          end
        end

        S_WAIT_IDLE: begin
          if (!sd_rdata_i[0]) begin
            state     <= S_START_RD;
            sd_cs_o   <= 1'b1;
            sd_rw_n_o <= 1'b0;
            sd_addr_o <= REG_CMD;
          end else if (tmo == TMO_LAST) begin
            state <= S_ERROR;
          end else begin
            tmo       <= tmo + TW'(1);
            sd_cs_o   <= 1'b1;
            sd_addr_o <= REG_STATUS;
          end
        end

        S_START_RD: begin
          state     <= S_POLL_DONE;
          tmo       <= '0;
          sd_cs_o   <= 1'b1;
          sd_addr_o <= REG_DONE;
        end

        S_POLL_DONE: begin
          if (sd_rdata_i[0]) begin
            state     <= S_SET_PAGE;
            page      <= '0;
            sd_cs_o   <= 1'b1;
            sd_rw_n_o <= 1'b0;
            sd_addr_o <= REG_PAGE;
          end else if (tmo == TMO_LAST) begin
            state <= S_ERROR;
          end else begin
            tmo       <= tmo + TW'(1);
            sd_cs_o   <= 1'b1;
            sd_addr_o <= REG_DONE;
          end
        end

        S_SET_PAGE: begin
          state     <= S_READ_BUF;
          idx       <= '0;
          sd_cs_o   <= 1'b1;
          sd_addr_o <= 8'h80;
        end

        S_READ_BUF: begin
          // The byte read this cycle is written to RAM during the next one.
          mem_we_o   <= 1'b1;
          mem_data_o <= sd_rdata_i;
          mem_addr_o <= mem_ptr;
          mem_ptr    <= mem_ptr + 16'd1;
          if (idx != 7'd127) begin
            idx       <= idx + 7'd1;
            sd_cs_o   <= 1'b1;
            sd_addr_o <= {1'b1, idx + 7'd1};
          end else if (page != 2'd3) begin
            page       <= page + 2'd1;
            state      <= S_SET_PAGE;
            sd_cs_o    <= 1'b1;
            sd_rw_n_o  <= 1'b0;
            sd_addr_o  <= REG_PAGE;
            sd_wdata_o <= {6'b0, page + 2'd1};
          end else begin
            state <= S_NEXT;
          end
        end

        S_NEXT: begin
          sec <= sec + 32'd1;
          cnt <= cnt - 8'd1;
          if (cnt == 8'd1) begin
            state <= S_FINISH;
          end else begin
            state     <= S_CLR_DONE;
            sd_cs_o   <= 1'b1;
            sd_addr_o <= REG_DONE;
          end
        end

        S_FINISH: begin
          busy_o <= 1'b0;
          done_o <= 1'b1;
          state  <= S_IDLE;
        end

        S_ERROR: begin
          busy_o  <= 1'b0;
          error_o <= 1'b1;
          state   <= S_IDLE;
        end

        default: state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_sd_sector_loader.sv
// Self-checking bench for sd_sector_loader: behavioural SD register model plus an
// expected-transfer reference built from sector/page/byte arithmetic.
module tb_sd_sector_loader;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        start = 1'b0;
  logic [31:0] sector_base = '0;
  logic [7:0]  sector_count = '0;
  logic [15:0] mem_base = '0;
  logic        sd_cs, sd_rw_n, mem_we, busy, cpu_hold, done, error;
  logic [7:0]  sd_addr, sd_wdata, sd_rdata, mem_data;
  logic [15:0] mem_addr;

  int vectors = 0;
  int miscompares = 0;

  sd_sector_loader #(.TW(24), .TIMEOUT_CYCLES(24'd100)) dut (
    .clk_i(clk), .rst_n_i(rst_n), .start_i(start),
    .sector_base_i(sector_base), .sector_count_i(sector_count), .mem_base_i(mem_base),
    .sd_cs_o(sd_cs), .sd_rw_n_o(sd_rw_n), .sd_addr_o(sd_addr), .sd_wdata_o(sd_wdata),
    .sd_rdata_i(sd_rdata), .mem_addr_o(mem_addr), .mem_data_o(mem_data), .mem_we_o(mem_we),
    .busy_o(busy), .cpu_hold_o(cpu_hold), .done_o(done), .error_o(error)
  );

  always #5 clk = ~clk;

  // ---------------- SD card register model ----------------
  logic [7:0] sec_reg [4] = '{default: 8'h00};
  logic [1:0] page_reg = 2'd0;
  logic       done_flag = 1'b0;
  int         done_cnt = 0;
  int         busy_cnt = 0;
  int         done_delay = 50;
  int         busy_max = 0;
  bit         never_done = 1'b0;
  logic [7:0] salt = 8'h00;

  // Sector buffer content: page*128+idx, offset by the sector's low byte times salt.
  function automatic logic [7:0] pattern(logic [7:0] s0, int p, int i, logic [7:0] k);
    int v;
    v = p * 128 + i + int'(s0) * int'(k);
    return v[7:0];
  endfunction

  always_comb begin
    sd_rdata = 8'h00;
    if (sd_addr == 8'h04)      sd_rdata = {7'b0, busy_cnt != 0};
    else if (sd_addr == 8'h0a) sd_rdata = {7'b0, done_flag};
    else if (sd_addr[7])       sd_rdata = pattern(sec_reg[0], int'(page_reg), int'(sd_addr[6:0]), salt);
  end

  always @(posedge clk) begin
    if (busy_cnt != 0) busy_cnt <= busy_cnt - 1;
    if (sd_cs && !sd_rw_n) begin
      if (sd_addr < 8'h04) sec_reg[sd_addr[1:0]] <= sd_wdata;
      if (sd_addr == 8'h00) busy_cnt <= $urandom_range(busy_max, 0);
      if (sd_addr == 8'h05) begin
        done_flag <= 1'b0;
        done_cnt  <= done_delay;
      end
      if (sd_addr == 8'h07) page_reg <= sd_wdata[1:0];
    end else if (sd_cs && sd_addr == 8'h0a) begin
      done_flag <= 1'b0;
    end
    if (done_cnt != 0) begin
      done_cnt <= done_cnt - 1;
      if (done_cnt == 1 && !never_done) done_flag <= 1'b1;
    end
  end

  // ---------------- bus / RAM monitor ----------------
  logic [15:0] wr_q [$];
  logic [23:0] mem_q [$];
  int cs_cycles = 0;
  int poll_0a = 0;

  always @(negedge clk) begin
    if (sd_cs) cs_cycles++;
    if (sd_cs && !sd_rw_n) wr_q.push_back({sd_addr, sd_wdata});
    if (sd_cs && !sd_rw_n && sd_addr == 8'h05) poll_0a = 0;
    else if (sd_cs && sd_rw_n && sd_addr == 8'h0a) poll_0a++;
    if (mem_we) mem_q.push_back({mem_addr, mem_data});
    vectors++;
    if (cpu_hold !== busy) begin
      miscompares++;
      $display("FAIL cpu_hold: got %b, want %b (busy)", cpu_hold, busy);
    end
  end

  function automatic logic [46:0] outs();
    return {sd_cs, sd_rw_n, sd_addr, sd_wdata, mem_addr, mem_data, mem_we, busy, cpu_hold, done, error};
  endfunction

  localparam logic [46:0] IDLE_OUTS = {1'b0, 1'b1, 45'd0};

  task automatic pulse_start(input logic [31:0] b, input logic [7:0] c, input logic [15:0] m);
    @(negedge clk);
    sector_base  = b;
    sector_count = c;
    mem_base     = m;
    start        = 1'b1;
    @(negedge clk);
    start        = 1'b0;
  endtask

  // Runs one load and compares every register write and RAM write with the reference.
  task automatic run_load(input logic [31:0] b, input logic [7:0] c, input logic [15:0] m,
                          input int glitch_at, input string name);
    int cyc;
    int budget;
    logic [31:0] s;
    logic [15:0] exp_wr [9];
    logic [15:0] ea;
    logic [7:0]  ed;
    wr_q.delete();
    mem_q.delete();
    budget = 700 * int'(c) + 200;
    pulse_start(b, c, m);
    cyc = 0;
    while (!(done === 1'b1 || error === 1'b1) && cyc < budget) begin
      @(negedge clk);
      cyc++;
      if (glitch_at != 0 && cyc == glitch_at) begin
        start = 1'b1; sector_base = ~b; sector_count = 8'd7; mem_base = ~m;
      end else begin
        start = 1'b0;
      end
    end
    start = 1'b0;
    vectors++;
    if (cyc >= budget) begin
      miscompares++;
      $display("FAIL %s timeout: no done/error after %0d cycles", name, cyc);
    end
    vectors++;
    if ({done, error, busy} !== 3'b100) begin
      miscompares++;
      $display("FAIL %s status: got done/error/busy=%b, want 100", name, {done, error, busy});
    end
    vectors++;
    if (wr_q.size() != 9 * int'(c)) begin
      miscompares++;
      $display("FAIL %s reg writes: got %0d, want %0d", name, wr_q.size(), 9 * int'(c));
    end else begin
      for (int n = 0; n < int'(c); n++) begin
        s = b + n;
        exp_wr = '{{8'h00, s[7:0]}, {8'h01, s[15:8]}, {8'h02, s[23:16]}, {8'h03, s[31:24]},
                   16'h0500, 16'h0700, 16'h0701, 16'h0702, 16'h0703};
        for (int j = 0; j < 9; j++) begin
          vectors++;
          if (wr_q[n * 9 + j] !== exp_wr[j]) begin
            miscompares++;
            $display("FAIL %s reg write %0d of sector %0d: got %h, want %h",
                     name, j, n, wr_q[n * 9 + j], exp_wr[j]);
          end
        end
      end
    end
    vectors++;
    if (mem_q.size() != 512 * int'(c)) begin
      miscompares++;
      $display("FAIL %s mem writes: got %0d, want %0d", name, mem_q.size(), 512 * int'(c));
    end else begin
      for (int k = 0; k < 512 * int'(c); k++) begin
        s  = b + k / 512;
        ea = m + 16'(k);
        ed = pattern(s[7:0], (k % 512) / 128, k % 128, salt);
        vectors++;
        if (mem_q[k] !== {ea, ed}) begin
          miscompares++;
          $display("FAIL %s mem write %0d: got addr/data %h, want %h", name, k, mem_q[k], {ea, ed});
        end
      end
    end
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    repeat (20) @(negedge clk);
    vectors++;
    if (outs() !== IDLE_OUTS) begin
      miscompares++;
      $display("FAIL reset outputs: got %h, want %h", outs(), IDLE_OUTS);
    end
    vectors++;
    if (cs_cycles != 0 || mem_q.size() != 0) begin
      miscompares++;
      $display("FAIL reset idle bus: got cs=%0d we=%0d, want 0 0", cs_cycles, mem_q.size());
    end
  endtask

  task automatic test_single();
    salt = 8'h00; done_delay = 50; busy_max = 0;
    run_load(32'h0000_0010, 8'd1, 16'h0200, 0, "single");
    foreach (mem_q[k]) begin
      vectors++;
      if (mem_q[k][7:0] !== mem_q[k][15:8]) begin
        miscompares++;
        $display("FAIL single data=addr[7:0] at %h: got %h", mem_q[k][23:8], mem_q[k][7:0]);
      end
    end
  endtask

  task automatic test_wrap();
    salt = 8'h03; done_delay = 20; busy_max = 3;
    run_load(32'hFFFF_FFFE, 8'd3, 16'hFF00, 0, "wrap");
  endtask

  task automatic test_random();
    for (int r = 0; r < 4; r++) begin
      salt       = 8'($urandom_range(255, 1));
      done_delay = $urandom_range(60, 1);
      busy_max   = $urandom_range(6, 0);
      run_load($urandom(), 8'($urandom_range(2, 1)), 16'($urandom()), 0, "random");
    end
  endtask

  task automatic test_ignore_start();
    salt = 8'h05; done_delay = 30; busy_max = 2;
    run_load(32'h1234_5678, 8'd1, 16'h4000, 300, "ignore_start");
  endtask

  task automatic test_timeout();
    int cyc;
    never_done = 1'b1;
    busy_max = 0;
    wr_q.delete();
    mem_q.delete();
    pulse_start($urandom(), 8'd1, 16'h1000);
    cyc = 0;
    while (error !== 1'b1 && cyc < 400) begin
      @(negedge clk);
      cyc++;
    end
    vectors++;
    if ({error, done, busy} !== 3'b100) begin
      miscompares++;
      $display("FAIL timeout status: got error/done/busy=%b, want 100", {error, done, busy});
    end
    vectors++;
    if (poll_0a != 100) begin
      miscompares++;
      $display("FAIL timeout polls: got %0d, want 100", poll_0a);
    end
    vectors++;
    if (mem_q.size() != 0) begin
      miscompares++;
      $display("FAIL timeout mem writes: got %0d, want 0", mem_q.size());
    end
    never_done = 1'b0;
  endtask

  task automatic test_zero_count();
    int cs0;
    cs0 = cs_cycles;
    pulse_start(32'h0000_0100, 8'd0, 16'h0000);
    @(negedge clk);
    vectors++;
    if ({done, error, busy} !== 3'b100) begin
      miscompares++;
      $display("FAIL zero_count status: got done/error/busy=%b, want 100", {done, error, busy});
    end
    vectors++;
    if (cs_cycles != cs0) begin
      miscompares++;
      $display("FAIL zero_count bus: got %0d cs cycles, want 0", cs_cycles - cs0);
    end
  endtask

  task automatic test_reset_mid();
    int cyc;
    int target;
    int cs0;
    int m0;
    salt = 8'h07; done_delay = 15; busy_max = 2;
    mem_q.delete();
    target = 256 + $urandom_range(100, 0);
    pulse_start(32'h0000_0040, 8'd2, 16'h8000);
    cyc = 0;
    while (mem_q.size() < target && cyc < 1000) begin
      @(negedge clk);
      cyc++;
    end
    vectors++;
    if (cyc >= 1000) begin
      miscompares++;
      $display("FAIL reset_mid reach page 2: got %0d writes, want %0d", mem_q.size(), target);
    end
    #2 rst_n = 1'b0;
    #1;
    vectors++;
    if (outs() !== IDLE_OUTS) begin
      miscompares++;
      $display("FAIL reset_mid outputs: got %h, want %h", outs(), IDLE_OUTS);
    end
    cs0 = cs_cycles;
    m0  = mem_q.size();
    repeat (5) @(negedge clk);
    vectors++;
    if (cs_cycles != cs0 || mem_q.size() != m0) begin
      miscompares++;
      $display("FAIL reset_mid activity: got cs=%0d we=%0d, want 0 0", cs_cycles - cs0, mem_q.size() - m0);
    end
    rst_n = 1'b1;
    repeat (2) @(negedge clk);
    run_load(32'hABCD_0001, 8'd2, 16'h7F80, 0, "after_reset");
  endtask

  initial begin
    test_reset();
    test_single();
    test_wrap();
    test_random();
    test_ignore_start();
    test_timeout();
    test_zero_count();
    test_reset_mid();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/sd_sector_loader.md
Name: sd_sector_loader

Overview:
- Hardware bus master that drives the SD-card register interface and copies a run of consecutive 512-byte sectors into main memory without CPU involvement.
- Used as the boot loader: it holds the 6502 off the bus (cpu_hold_o) while it loads, then releases it.
- It is the initiator of the SD register protocol, and it writes the data it reads into the system RAM write port.

Parameters:
- TIMEOUT_CYCLES, 24'd4000000: cycles allowed in any single poll loop (busy-wait or done-wait) before error.
- TW, 24: width of the timeout counter.

Ports:
- clk_i  in  1  system clock, rising edge.
- rst_n_i  in  1  asynchronous, active-low reset.
- start_i  in  1  one-cycle start pulse; sampled only in IDLE.
- sector_base_i  in  32  first SD sector number; latched on start.
- sector_count_i  in  8  number of sectors to load; latched on start.
- mem_base_i  in  16  destination RAM byte address; latched on start.
- sd_cs_o  out  1  register-interface select.
- sd_rw_n_o  out  1  1 = read, 0 = write.
- sd_addr_o  out  8  register address.
- sd_wdata_o  out  8  register write data.
- sd_rdata_i  in  8  register read data; sampled at the rising edge ending an access cycle.
- mem_addr_o  out  16  RAM write address.
- mem_data_o  out  8  RAM write data.
- mem_we_o  out  1  RAM write strobe; one cycle per byte.
- busy_o  out  1  load in progress.
- cpu_hold_o  out  1  equals busy_o.
- done_o  out  1  level; set on success, cleared by the next accepted start.
- error_o  out  1  level; set on timeout, cleared by the next accepted start.

Behaviour:
- Reset values: all outputs 0 except sd_rw_n_o = 1. State is IDLE.
- Reset asserted mid-load aborts immediately; no further bus or RAM cycles occur.
- Bus access rule: every register access is exactly one cycle with sd_cs_o = 1.
  - Writes take effect at that cycle's rising edge.
  - Read data is sampled at the same edge.
  - Between states, sd_cs_o may stay high for consecutive accesses.
  - When no access is needed, sd_cs_o = 0 and sd_rw_n_o = 1.
- States and transitions:
  - IDLE: on start_i, latch sec, cnt and mem_ptr; clear done_o and error_o.
    - If cnt == 0, set done_o the next cycle and stay in IDLE.
    - Otherwise set busy_o and go to CLR_DONE.
  - CLR_DONE: one read of 0x0a to discard any stale done latch, then go to SET_ADDR.
  - SET_ADDR: 4 consecutive writes, 0x00..0x03 = sec[7:0], sec[15:8], sec[23:16], sec[31:24]. Then go to WAIT_IDLE.
  - WAIT_IDLE: read 0x04 every cycle.
    - If bit0 == 0, go to START_RD.
    - Timeout goes to ERROR.
  - START_RD: one write to 0x05 (data 0x00), then go to POLL_DONE.
  - POLL_DONE: read 0x0a every cycle.
    - If bit0 == 1, set page = 0 and go to SET_PAGE.
    - Timeout goes to ERROR.
  - SET_PAGE: one write to 0x07 = {6'b0, page}, then go to READ_BUF with idx = 0.
  - READ_BUF: 128 consecutive reads of 0x80 + idx, idx = 0..127.
    - After idx 127: if page < 3, page++ and go to SET_PAGE; else go to NEXT.
  - NEXT: sec++ (32-bit wrap), cnt--.
    - If cnt becomes 0, go to FINISH; else go to CLR_DONE.
  - FINISH: wait one cycle for the last RAM write, then clear busy_o, set done_o, go to IDLE.
  - ERROR: clear busy_o, set error_o, drive the bus idle, go to IDLE.
- Timeout: the counter resets on entry to WAIT_IDLE or POLL_DONE. When it reaches TIMEOUT_CYCLES-1 without success, the state goes to ERROR.
- RAM write pipeline:
  - The byte sampled at the end of a READ_BUF cycle appears on mem_data_o with mem_we_o = 1 in the following cycle, with mem_addr_o = mem_ptr. mem_ptr then increments (16-bit wrap, no error on wrap).
  - Exactly 512 mem_we_o pulses per sector. Byte order: page 0 idx 0 first, through page 3 idx 127.
- start_i while busy_o = 1 is ignored.
- Total cycles per sector, excluding poll time: 1 + 4 + 1 + 4 × (1 + 128) + 1 = 523.

Test Plan:
- Reset, then idle 20 cycles -> all outputs 0, sd_rw_n_o = 1, no sd_cs_o or mem_we_o activity.
- start with sector_base 0x00000010, count 1, mem_base 0x0200; SD model returns byte = (page × 128 + idx) & 0xFF, done after 50 cycles ->
  - writes 0x10, 0x00, 0x00, 0x00 to regs 0x00..0x03, then 0x05;
  - 512 mem writes to 0x0200..0x03FF with data equal to address[7:0];
  - done_o = 1, busy_o = 0.
- count 3, sector_base 0xFFFFFFFE, mem_base 0xFF00 -> sector addresses written are FFFFFFFE, FFFFFFFF, 00000000; mem_addr wraps 0xFFFF -> 0x0000; 1536 writes; done_o = 1.
- TIMEOUT_CYCLES = 100, SD model never sets done -> after 100 polls of 0x0a, error_o = 1, done_o = 0, busy_o = 0, zero mem_we_o pulses.
- count 0 -> done_o = 1 two cycles after start, no sd_cs_o assertion. start pulsed again mid-load -> ignored, sequence unchanged.
- Assert rst_n_i during READ_BUF of page 2 -> outputs at reset values immediately. A new start then completes a full clean load.
